// File: rtl/uart_defs.sv
// -----------------------------------------------------------------------------
// uart_defs
// Shared definitions for the UART transmit unit: FSM state encodings, the
// UART data width and the line levels used for idle, start and stop bits.
// The PARITY encoding is always present so state values stay identical
// whether or not the parity build option (UART_TX_PARITY_EN) is enabled.
// -----------------------------------------------------------------------------
package uart_defs;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Small show-ahead byte FIFO that absorbs bursts of OUT instructions while a
// UART frame is in flight. The head entry is always visible on pop_data.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high; empties the FIFO
//   push      in   write push_data when not full
//   push_data in   byte to store
//   pop       in   discard the head entry when not empty
//   pop_data  out  head entry (valid while empty=0)
//   full      out  FIFO holds FIFO_DEPTH entries
//   empty     out  FIFO holds no entries
//   overflow  out  registered one-cycle pulse after a push was dropped
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_defs::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [UART_DATA_W-1:0] push_data,
    input  logic                   pop,
    output logic [UART_DATA_W-1:0] pop_data,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [UART_DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   overflow_q;
    logic                   push_ok;
    logic                   pop_ok;

    // Fullness is judged on the count before the edge, so a push into a full
    // FIFO is dropped even when a pop frees a slot in the same cycle.
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign pop_data = mem[rd_ptr];
    assign overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Pointers are exactly PTR_W bits wide, so they wrap modulo depth.
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            overflow_q <= push & full;
        end
    end

    // Storage carries data only and needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_unit.sv
// -----------------------------------------------------------------------------
// uart_tx_unit
// Captures the accumulator byte on each uart_send strobe from the control
// decoder, buffers it in a small FIFO and serialises it as 8N1 UART frames.
// Frames queued back to back are sent with no idle gap between them.
//
// Build option: UART_TX_PARITY_EN -- when defined, an even-parity bit is sent
// between the last data bit and the stop bit (11-bit frames).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high; aborts any frame, drops FIFO
//   uart_send  in   push strobe, one byte per asserted cycle
//   tx_data    in   byte sampled when uart_send=1
//   tx         out  serial line, idle high (registered)
//   busy       out  frame in progress or bytes pending (registered)
//   fifo_full  out  FIFO holds FIFO_DEPTH entries
//   overflow   out  one-cycle registered pulse when a push is dropped
// -----------------------------------------------------------------------------
module uart_tx_unit
    import uart_defs::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   uart_send,
    input  logic [UART_DATA_W-1:0] tx_data,
    output logic                   tx,
    output logic                   busy,
    output logic                   fifo_full,
    output logic                   overflow
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   busy_q;
    logic                   bit_done;
    logic                   pop;
    logic                   fifo_empty;
    logic [UART_DATA_W-1:0] fifo_head;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (uart_send),
        .push_data (tx_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (overflow)
    );

    assign bit_done = (cnt_q == CNT_LAST);

    // Next-state, bit timer, shift register and next line level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        if (state_q != ST_IDLE) begin
            cnt_d = bit_done ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                    cnt_d   = '0;
                    shift_d = fifo_head;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_head;
`endif
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    // Chain straight into the next frame when bytes are waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_START;
                        shift_d = fifo_head;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_head;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // tx is registered, so its next value follows the next state.
        case (state_d)
            ST_START: tx_d = LINE_START;
            ST_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            ST_STOP:  tx_d = LINE_STOP;
            default:  tx_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            // Pending bytes are judged before the edge so busy rises together
            // with the start bit and falls right after the last stop cycle.
            busy_q  <= (state_d != ST_IDLE) | ~fifo_empty;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
        parity_q <= parity_d;
`endif
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_unit
// Randomised and directed stimulus for uart_tx_unit with a cycle-level
// reference model of the transmitter (byte queue plus remaining frame time)
// and a scoreboard fed by a serial-line receiver that decodes frames on tx.
// -----------------------------------------------------------------------------
module tb_uart_tx_unit;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_send;
    logic [7:0] tx_data;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       overflow;

    always #5 clk = ~clk;

    uart_tx_unit #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_send (uart_send),
        .tx_data   (tx_data),
        .tx        (tx),
        .busy      (busy),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rst_epoch = 0;

    // Reference model state: bytes waiting, byte on the line, cycles left.
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic [7:0] cur;
    int         rem;
    logic       exp_tx, exp_busy, exp_full, exp_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic model_tx();
        int pos, b;
        if (rem == 0) return 1'b1;
        pos = FRAME - rem;
        b   = pos / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^cur;
`endif
        return 1'b1;
    endfunction

    // Advance the model across one rising edge using the pre-edge state.
    task automatic model_step(input logic s, input logic [7:0] d, input logic r);
        bit pre_full, pre_nonempty;
        if (r) begin
            mq.delete();
            rem      = 0;
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
            exp_full = 1'b0;
            exp_ovf  = 1'b0;
            return;
        end
        pre_full     = (mq.size() == DEPTH);
        pre_nonempty = (mq.size() != 0);
        if (rem <= 1 && pre_nonempty) begin
            cur = mq.pop_front();
            rem = FRAME;
        end else if (rem > 0) begin
            rem--;
        end
        exp_ovf = 1'b0;
        if (s) begin
            if (pre_full) begin
                exp_ovf = 1'b1;
            end else begin
                mq.push_back(d);
                exp_q.push_back(d);
            end
        end
        exp_full = (mq.size() == DEPTH);
        exp_busy = (rem > 0) || pre_nonempty;
        exp_tx   = model_tx();
    endtask

    // One clock: check outputs, drive inputs, update model, cross the edge.
    task automatic cycle(input logic s, input logic [7:0] d, input logic r);
        chk("tx", tx, exp_tx);
        chk("busy", busy, exp_busy);
        chk("fifo_full", fifo_full, exp_full);
        chk("overflow", overflow, exp_ovf);
        reset     = r;
        uart_send = s;
        tx_data   = d;
        model_step(s, d, r);
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            rst_epoch++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 3000 && (rem != 0 || mq.size() != 0); k++) cycle(1'b0, 8'h00, 1'b0);
        repeat (4) cycle(1'b0, 8'h00, 1'b0);
        chk("drain_idle", (rem == 0 && mq.size() == 0), 1);
        chk("frames_outstanding", exp_q.size(), 0);
    endtask

    // Serial receiver: samples each bit in its middle and scores the frame.
    task automatic mon_wait(input int n, input int ep, output bit ab);
        ab = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
            if (rst_epoch != ep) begin
                ab = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        logic       mon_prev;
        logic [7:0] b;
        logic [7:0] e;
        logic       st, sp, par;
        int         ep;
        bit         ab;
        mon_prev = 1'b1;
        par      = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (mon_prev === 1'b1 && tx === 1'b0) begin
                ep = rst_epoch;
                b  = 8'h00;
                mon_wait(CPB / 2, ep, ab);
                st = tx;
                for (int i = 0; i < 8 && !ab; i++) begin
                    mon_wait(CPB, ep, ab);
                    b[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                if (!ab) begin
                    mon_wait(CPB, ep, ab);
                    par = tx;
                end
`endif
                if (!ab) mon_wait(CPB, ep, ab);
                sp = tx;
                if (!ab) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL frame_unexpected: got byte %0h, expected no frame", b);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_data", b, e);
                        chk("frame_start", st, 0);
                        chk("frame_stop", sp, 1);
`ifdef UART_TX_PARITY_EN
                        chk("frame_parity", par, ^e);
`endif
                    end
                end
            end
            mon_prev = tx;
        end
    end

    initial begin
        reset     = 1'b1;
        uart_send = 1'b0;
        tx_data   = 8'h00;
        rem       = 0;
        cur       = 8'h00;
        exp_tx    = 1'b1;
        exp_busy  = 1'b0;
        exp_full  = 1'b0;
        exp_ovf   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Quiet line after reset.
        repeat (20) cycle(1'b0, 8'h00, 1'b0);

        // Single byte.
        cycle(1'b1, 8'hA5, 1'b0);
        drain();

        // Three back-to-back bytes.
        for (int i = 1; i <= 3; i++) cycle(1'b1, 8'(i), 1'b0);
        drain();

        // Burst of six: last one overflows.
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
        drain();

        // Reset during data bit 3 of the first of two queued frames.
        cycle(1'b1, 8'h3C, 1'b0);
        cycle(1'b1, 8'hC3, 1'b0);
        for (int k = 0; k < 100 && !(rem > 0 && (FRAME - rem) / CPB == 4); k++)
            cycle(1'b0, 8'h00, 1'b0);
        chk("reached_data_bit3", (rem > 0 && (FRAME - rem) / CPB == 4), 1);
        cycle(1'b0, 8'h00, 1'b1);
        repeat (60) cycle(1'b0, 8'h00, 1'b0);

`ifdef UART_TX_PARITY_EN
        cycle(1'b1, 8'h07, 1'b0);
        drain();
        cycle(1'b1, 8'h03, 1'b0);
        drain();
`endif

        // Random traffic, heavy then light, with occasional resets.
        for (int i = 0; i < 600; i++)
            cycle(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 249) == 0));
        drain();
        for (int i = 0; i < 600; i++)
            cycle(($urandom_range(0, 39) == 0), 8'($urandom), 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
